// File: rtl/if_id_buffer_if.sv
// Fetch/decode handshake bundle around the IF/ID buffer.
// The slave side is the buffer itself. The master side is whoever drives fetch
// words in, consumes the head and raises flush.
interface if_id_buffer_if #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
) ();
    logic               in_valid;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc4;
    logic               in_ready;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc4;
    logic               out_ready;
    logic               flush;

    modport slave (
        input  in_valid, in_instr, in_pc4, out_ready, flush,
        output in_ready, out_valid, out_instr, out_pc4
    );

    modport master (
        output in_valid, in_instr, in_pc4, out_ready, flush,
        input  in_ready, out_valid, out_instr, out_pc4
    );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer.
// This is a small FIFO of {instruction, PC+4} pairs between fetch and decode.
// in_ready comes only from the registered occupancy, so there is no
// combinational path from out_ready to in_ready.
// A taken branch or jump flushes every queued word. The number of discarded
// entries is accumulated in a saturating counter.
module if_id_buffer #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    if_id_buffer_if.slave          bus,
    output logic [$clog2(DEPTH):0] count,
    output logic [CNT_W-1:0]       drop_cnt
);
    localparam int            PTR_W = $clog2(DEPTH);
    localparam int            CW    = PTR_W + 1;
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam int            SW    = CNT_W + CW + 1;

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PC_W-1:0]    pc4_mem   [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    // Saturating accumulate of flushed entries. The sum is wide enough that it never wraps.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                                 input logic [CW-1:0]    inc);
        logic [SW-1:0] sum;
        sum = SW'(acc) + SW'(inc);
        if (sum > SW'({CNT_W{1'b1}}))
            return {CNT_W{1'b1}};
        return sum[CNT_W-1:0];
    endfunction

    assign full          = (count == FULL);
    assign empty         = (count == '0);
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;

    // flush wins over both handshakes, so a word offered during a flush is dropped.
    assign push = bus.in_valid & !full & !bus.flush;
    assign pop  = !empty & bus.out_ready & !bus.flush;

    // The head is masked to zero (NOP) while the buffer is empty. There is no bypass from the input.
    assign bus.out_instr = empty ? '0 : instr_mem[rd_ptr];
    assign bus.out_pc4   = empty ? '0 : pc4_mem[rd_ptr];

    // Capture the fetched word and its PC+4 into the tail slot. The storage has no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= bus.in_instr;
            pc4_mem[wr_ptr]   <= bus.in_pc4;
        end
    end

    // Pointer, occupancy and drop-counter update. flush has the highest priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else if (bus.flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= sat_add(drop_cnt, count);
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_if_id_buffer.sv
// Testbench for if_id_buffer.
// The bench drives words through a vector table and hand-written sequences.
// A queue-based scoreboard tracks the expected head, occupancy and drop count.
// A second instance with a 2-bit drop counter exercises saturation.
module tb_if_id_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  count;
    logic [15:0] drop_cnt;
    logic [1:0]  count2;
    logic [1:0]  drop2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    entry_t q[$];
    int     m_drop = 0;

    typedef struct {
        logic        iv;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        ordy;
        logic        fl;
        logic [1:0]  e_cnt;
        logic        e_valid;
        logic        e_ready;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic [15:0] e_drop;
    } vec_t;

    vec_t vecs[9];

    if_id_buffer_if #(.INSTR_W(32), .PC_W(32)) bus  ();
    if_id_buffer_if #(.INSTR_W(32), .PC_W(32)) bus2 ();

    if_id_buffer #(.INSTR_W(32), .PC_W(32), .DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .count(count), .drop_cnt(drop_cnt)
    );

    if_id_buffer #(.INSTR_W(32), .PC_W(32), .DEPTH(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .count(count2), .drop_cnt(drop2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock on the main DUT. The scoreboard is checked before the edge and the occupancy after it.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        bit do_push;
        bit do_pop;
        bus.in_valid  = iv;
        bus.in_instr  = ins;
        bus.in_pc4    = pc;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, q.size() != 0});
        chk("in_ready", {63'd0, bus.in_ready}, {63'd0, q.size() < 2});
        if (q.size() != 0) begin
            chk("head_instr", {32'd0, bus.out_instr}, {32'd0, q[0].instr});
            chk("head_pc4", {32'd0, bus.out_pc4}, {32'd0, q[0].pc4});
        end else begin
            chk("empty_instr", {32'd0, bus.out_instr}, 64'd0);
        end
        if (fl) begin
            m_drop = (m_drop + q.size() > 65535) ? 65535 : m_drop + q.size();
            q.delete();
        end else begin
            do_pop  = ordy && q.size() != 0;
            do_push = iv && q.size() < 2;
            if (do_pop)
                void'(q.pop_front());
            if (do_push)
                q.push_back('{ins, pc});
        end
        @(posedge clk);
        #1;
        chk("count", {62'd0, count}, 64'(q.size()));
        chk("drop_cnt", {48'd0, drop_cnt}, 64'(m_drop));
    endtask

    // One clock on the saturation instance.
    task automatic step2(input logic iv, input logic [31:0] ins, input logic fl);
        bus2.in_valid  = iv;
        bus2.in_instr  = ins;
        bus2.in_pc4    = ins;
        bus2.out_ready = 1'b0;
        bus2.flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h2008000A, 32'h4,  1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'h2008000A, 32'h4, 16'd0};
        vecs[1] = '{1'b0, 32'h0,        32'h0,  1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'h0,        32'h0, 16'd0};
        vecs[2] = '{1'b1, 32'h11111111, 32'h8,  1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'h11111111, 32'h8, 16'd0};
        vecs[3] = '{1'b1, 32'h22222222, 32'hC,  1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'h11111111, 32'h8, 16'd0};
        vecs[4] = '{1'b1, 32'h33333333, 32'h10, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'h11111111, 32'h8, 16'd0};
        vecs[5] = '{1'b0, 32'h0,        32'h0,  1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h22222222, 32'hC, 16'd0};
        vecs[6] = '{1'b1, 32'h44444444, 32'h14, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'h22222222, 32'hC, 16'd0};
        vecs[7] = '{1'b1, 32'h55555555, 32'h18, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 32'h0,        32'h0, 16'd2};
        vecs[8] = '{1'b0, 32'h0,        32'h0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 32'h0,        32'h0, 16'd2};

        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc4 = '0; bus.out_ready = 1'b0; bus.flush = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_instr = '0; bus2.in_pc4 = '0; bus2.out_ready = 1'b0; bus2.flush = 1'b0;

        // Reset state while rst_n is held low.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", {62'd0, count}, 64'd0);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_instr", {32'd0, bus.out_instr}, 64'd0);
        chk("rst_drop", {48'd0, drop_cnt}, 64'd0);
        rst_n = 1'b1;

        // Table: single word, fill/back-pressure, pop from full, flush with handshakes.
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].iv, vecs[i].instr, vecs[i].pc4, vecs[i].ordy, vecs[i].fl);
            chk($sformatf("v%0d_count", i), {62'd0, count}, {62'd0, vecs[i].e_cnt});
            chk($sformatf("v%0d_valid", i), {63'd0, bus.out_valid}, {63'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_ready", i), {63'd0, bus.in_ready}, {63'd0, vecs[i].e_ready});
            chk($sformatf("v%0d_instr", i), {32'd0, bus.out_instr}, {32'd0, vecs[i].e_instr});
            chk($sformatf("v%0d_pc4", i), {32'd0, bus.out_pc4}, {32'd0, vecs[i].e_pc4});
            chk($sformatf("v%0d_drop", i), {48'd0, drop_cnt}, {48'd0, vecs[i].e_drop});
        end

        // Streaming: 8 words with PC+4 from 4 to 32. Both pointers wrap four times.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'hA0000000 + 32'(i), 32'(4 * (i + 1)), 1'b1, 1'b0);
            chk("stream_count", {62'd0, count}, 64'd1);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("stream_drained", {62'd0, count}, 64'd0);

        // Saturation on the 2-bit drop counter: 2, 3, 3.
        for (int k = 0; k < 3; k++) begin
            step2(1'b1, 32'h10 + 32'(k), 1'b0);
            step2(1'b1, 32'h20 + 32'(k), 1'b0);
            chk("sat_fill", {62'd0, count2}, 64'd2);
            step2(1'b0, 32'h0, 1'b1);
            chk("sat_count", {62'd0, count2}, 64'd0);
            chk($sformatf("sat_drop%0d", k), {62'd0, drop2}, (k == 0) ? 64'd2 : 64'd3);
        end
        step2(1'b0, 32'h0, 1'b0);

        // Asynchronous reset mid-cycle while the buffer holds words.
        step(1'b1, 32'hDEADBEEF, 32'h40, 1'b0, 1'b0);
        step(1'b1, 32'hFEEDFACE, 32'h44, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_count", {62'd0, count}, 64'd0);
        chk("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("arst_out_instr", {32'd0, bus.out_instr}, 64'd0);
        chk("arst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("arst_drop", {48'd0, drop_cnt}, 64'd0);
        chk("arst_drop_sat", {62'd0, drop2}, 64'd0);
        q.delete();
        m_drop = 0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Normal operation after reset release.
        step(1'b1, 32'hCAFEF00D, 32'h80, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
